// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch queue
package fetch_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_AW    = 16;
    localparam int FQ_IW    = 16;

    typedef logic [FQ_AW-1:0] addr_t;
    typedef logic [FQ_IW-1:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// rtl/fetch_fifo_mem.sv - fetch queue storage: one write port, async read port
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  fq_entry_t                wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output fq_entry_t                rdata_o
);

    // Storage is deliberately unreset; validity is tracked by the pointers.
    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - pairs imem read data with its PC and buffers it for decode
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int IW    = FQ_IW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            pc_i,
    input  logic                     pc_valid_i,
    output logic                     stall_o,
    input  logic                     flush_i,
    output logic                     imem_en_o,
    output logic [AW-1:0]            imem_addr_o,
    input  logic [IW-1:0]            imem_rdata_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [IW-1:0]            id_instr_o,
    output logic [AW-1:0]            id_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, inflight_d;
    addr_t         pc_q, pc_d;

    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;
    fq_entry_t     wr_entry;
    fq_entry_t     rd_entry;

    // Counting the in-flight read reserves its slot, so the FIFO never overflows
    // and stall depends only on registered state.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign stall_o   = occupancy >= (CW+1)'(DEPTH);

    assign imem_en_o   = rst_n & pc_valid_i & ~stall_o & ~flush_i;
    assign imem_addr_o = pc_i;

    assign id_valid_o = (count_q != '0);
    assign push       = inflight_q & ~flush_i;
    assign pop        = id_valid_o & id_ready_i & ~flush_i;

    assign wr_entry.pc    = addr_t'(pc_q);
    assign wr_entry.instr = instr_t'(imem_rdata_i);

    fetch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Head fields read as zero when empty, hiding the unreset storage.
    assign id_pc_o    = id_valid_o ? AW'(rd_entry.pc)    : '0;
    assign id_instr_o = id_valid_o ? IW'(rd_entry.instr) : '0;
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = imem_en_o;
        pc_d       = imem_en_o ? addr_t'(pc_i) : pc_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

endmodule
